// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  // Default geometry: the classic 32 x 32-bit general-purpose register file.
  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;

  // Architectural zero register index.
  localparam int ZERO_ADDR = 0;

  // Ceiling log2, usable in parameter defaults on tools that lack $clog2.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < value) begin
        result = k + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination as having a
// pending producer, a clearing write from writeback retires it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = clog2(DEPTH),
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR-1:0]    wr_clr,
  output logic [DEPTH-1:0]  busy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_next;

  // Clears are applied first and the issue set last, so a new producer
  // issued in the same cycle as the old one retires keeps the bit set.
  always_comb begin
    busy_next = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_clr[j]) begin
        busy_next[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_next[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_next[ZERO_ADDR] = 1'b0;
    end
  end

  // Busy register; reset drops every pending producer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register,
// optional write-to-read bypass and a busy scoreboard for RAW stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*DW-1:0] wr_data,
  input  logic [NWR-1:0]    wr_clr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr
);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;

  // True when the address names the hard-wired zero register.
  function automatic logic is_zero(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == AW'(ZERO_ADDR));
  endfunction

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_clr   (wr_clr),
    .busy     (busy)
  );

  // Storage array; ports are visited in ascending order so the highest
  // index writing an address wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && !is_zero(wr_addr[j*AW +: AW])) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
        end
      end
    end
  end

  // Read muxes: array lookup, then same-cycle forwarding (highest write
  // port wins, suppressed in reset), then the zero-register override.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*DW +: DW] = regs[rd_addr[i*AW +: AW]];
      rd_busy[i]          = busy[rd_addr[i*AW +: AW]];
      if ((BYPASS != 0) && rst_n) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
            rd_data[i*DW +: DW] = wr_data[j*DW +: DW];
            if (wr_clr[j]) begin
              rd_busy[i] = 1'b0;
            end
          end
        end
      end
      if (is_zero(rd_addr[i*AW +: AW])) begin
        rd_data[i*DW +: DW] = '0;
        rd_busy[i]          = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: one bypassing and one non-bypassing instance
// share stimulus and are checked against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     rd_addr_a [NRD];
  logic [AW-1:0]     wr_addr_a [NWR];
  logic [DW-1:0]     wr_data_a [NWR];
  logic [NWR-1:0]    wr_en;
  logic [NWR-1:0]    wr_clr;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;

  logic [NRD*AW-1:0] rd_addr;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NRD*DW-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]    rd_busy_b, rd_busy_n;

  // Reference state: register contents and busy flags
  logic [DW-1:0]     m_regs [DEPTH];
  bit                m_busy [DEPTH];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  // Pack per-port stimulus arrays into the flat DUT buses
  always_comb begin
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = rd_addr_a[i];
    for (int j = 0; j < NWR; j++) begin
      wr_addr[j*AW +: AW] = wr_addr_a[j];
      wr_data[j*DW +: DW] = wr_data_a[j];
    end
  end

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)) dut_nbyp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < DEPTH; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Expected read data: stored value, forwarded write data (later port wins), r0 = 0
  function automatic logic [DW-1:0] expData(input int port, input bit byp);
    logic [DW-1:0] d;
    int a;
    a = int'(rd_addr_a[port]);
    if (!rst_n || a == 0) return '0;
    d = m_regs[a];
    if (byp) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && int'(wr_addr_a[j]) == a) d = wr_data_a[j];
      end
    end
    return d;
  endfunction

  // Expected busy: pending flag, hidden by a same-cycle retiring write when forwarding
  function automatic logic expBusy(input int port, input bit byp);
    int a;
    a = int'(rd_addr_a[port]);
    if (!rst_n || a == 0) return 1'b0;
    if (byp) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_clr[j] && int'(wr_addr_a[j]) == a) return 1'b0;
      end
    end
    return m_busy[a];
  endfunction

  task automatic checkReads(input string tag);
    for (int i = 0; i < NRD; i++) begin
      checkOutput($sformatf("%s_byp_data%0d", tag, i), rd_data_b[i*DW +: DW], expData(i, 1'b1));
      checkOutput($sformatf("%s_byp_busy%0d", tag, i), DW'(rd_busy_b[i]), DW'(expBusy(i, 1'b1)));
      checkOutput($sformatf("%s_nbyp_data%0d", tag, i), rd_data_n[i*DW +: DW], expData(i, 1'b0));
      checkOutput($sformatf("%s_nbyp_busy%0d", tag, i), DW'(rd_busy_n[i]), DW'(expBusy(i, 1'b0)));
    end
  endtask

  // Advance one edge and apply the edge rules to the model
  task automatic stepClock();
    logic [DW-1:0] nregs [DEPTH];
    @(posedge clk);
    if (!rst_n) begin
      modelReset();
    end else begin
      for (int r = 0; r < DEPTH; r++) nregs[r] = m_regs[r];
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr_a[j] != 0) nregs[wr_addr_a[j]] = wr_data_a[j];
        if (wr_en[j] && wr_clr[j]) m_busy[wr_addr_a[j]] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      for (int r = 0; r < DEPTH; r++) m_regs[r] = nregs[r];
    end
    #1;
  endtask

  task automatic clearInputs();
    for (int i = 0; i < NRD; i++) rd_addr_a[i] = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_addr_a[j] = '0;
      wr_data_a[j] = '0;
    end
    wr_en    = '0;
    wr_clr   = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
  endtask

  task automatic setWrite(input int port, input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic clr);
    wr_en[port]     = 1'b1;
    wr_addr_a[port] = addr;
    wr_data_a[port] = data;
    wr_clr[port]    = clr;
  endtask

  // Random transaction on a narrow address window to force collisions
  task automatic applyStimulus();
    for (int i = 0; i < NRD; i++)
      rd_addr_a[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
    for (int j = 0; j < NWR; j++) begin
      wr_en[j]     = ($urandom_range(0, 2) != 0);
      wr_clr[j]    = $urandom_range(0, 1) == 1;
      wr_addr_a[j] = AW'($urandom_range(0, 7));
      wr_data_a[j] = $urandom;
    end
    iss_en   = $urandom_range(0, 2) == 0;
    iss_addr = AW'($urandom_range(0, 7));
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;
    modelReset();
    #2;
    rd_addr_a[0] = 5'd0;  rd_addr_a[1] = 5'd5;
    #1 checkReads("reset_a");
    rd_addr_a[0] = 5'd31; rd_addr_a[1] = 5'd5;
    #1 checkReads("reset_b");
    stepClock();
    rst_n = 1'b1;
    #2;

    // Plain write: non-bypass copy sees it only after the edge
    clearInputs();
    setWrite(0, 5'd5, 32'hDEADBEEF, 1'b0);
    rd_addr_a[0] = 5'd5;
    #1 checkOutput("wr_nbyp_same_cycle", rd_data_n[31:0], 32'h0);
    checkOutput("wr_byp_same_cycle", rd_data_b[31:0], 32'hDEADBEEF);
    stepClock();
    clearInputs();
    rd_addr_a[0] = 5'd5;
    #1 checkOutput("wr_nbyp_next_cycle", rd_data_n[31:0], 32'hDEADBEEF);
    checkReads("wr");

    // Both ports write r7: port 1 must win for forwarding and storage
    setWrite(0, 5'd7, 32'h11, 1'b0);
    setWrite(1, 5'd7, 32'h22, 1'b0);
    rd_addr_a[1] = 5'd7;
    #1 checkOutput("prio_byp_same_cycle", rd_data_b[63:32], 32'h22);
    stepClock();
    clearInputs();
    rd_addr_a[1] = 5'd7;
    #1 checkOutput("prio_nbyp_stored", rd_data_n[63:32], 32'h22);
    checkOutput("prio_byp_stored", rd_data_b[63:32], 32'h22);

    // Zero register ignores writes and issue
    setWrite(0, 5'd0, 32'hFFFFFFFF, 1'b1);
    iss_en = 1'b1; iss_addr = 5'd0;
    #1 checkOutput("zero_byp_same_cycle", rd_data_b[31:0], 32'h0);
    stepClock();
    clearInputs();
    #1 checkOutput("zero_data_after", rd_data_b[31:0], 32'h0);
    checkOutput("zero_busy_after", DW'(rd_busy_b[0]), 32'h0);
    checkOutput("zero_nbyp_busy_after", DW'(rd_busy_n[0]), 32'h0);

    // Scoreboard sequence on r3
    iss_en = 1'b1; iss_addr = 5'd3;
    stepClock();
    clearInputs();
    rd_addr_a[0] = 5'd3;
    #1 checkOutput("sb_issue_busy", DW'(rd_busy_b[0]), 32'h1);
    setWrite(0, 5'd3, 32'h33, 1'b0);
    #1 checkOutput("sb_noclr_busy_same", DW'(rd_busy_b[0]), 32'h1);
    stepClock();
    clearInputs();
    rd_addr_a[0] = 5'd3;
    #1 checkOutput("sb_noclr_busy_after", DW'(rd_busy_b[0]), 32'h1);
    setWrite(1, 5'd3, 32'h34, 1'b1);
    #1 checkOutput("sb_clr_byp_masked", DW'(rd_busy_b[0]), 32'h0);
    checkOutput("sb_clr_nbyp_still", DW'(rd_busy_n[0]), 32'h1);
    stepClock();
    clearInputs();
    rd_addr_a[0] = 5'd3;
    #1 checkOutput("sb_clr_after", DW'(rd_busy_n[0]), 32'h0);
    iss_en = 1'b1; iss_addr = 5'd3;
    setWrite(0, 5'd3, 32'h35, 1'b1);
    stepClock();
    clearInputs();
    rd_addr_a[0] = 5'd3;
    #1 checkOutput("sb_set_wins", DW'(rd_busy_n[0]), 32'h1);
    checkReads("sb");

    // Asynchronous reset between edges
    setWrite(0, 5'd9, 32'hA5, 1'b0);
    iss_en = 1'b1; iss_addr = 5'd9;
    stepClock();
    clearInputs();
    rd_addr_a[0] = 5'd9; rd_addr_a[1] = 5'd3;
    #1 checkOutput("async_pre_data", rd_data_n[31:0], 32'hA5);
    checkOutput("async_pre_busy", DW'(rd_busy_n[0]), 32'h1);
    rst_n = 1'b0;
    modelReset();
    #1 checkOutput("async_data", rd_data_n[31:0], 32'h0);
    checkOutput("async_busy", DW'(rd_busy_n[0]), 32'h0);
    checkReads("async");
    stepClock();
    rst_n = 1'b1;

    // Randomised traffic with occasional mid-cycle resets
    for (int c = 0; c < 400; c++) begin
      applyStimulus();
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        modelReset();
      end
      #2 checkReads($sformatf("rnd%0d", c));
      stepClock();
      rst_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
